pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, PLL reset pulse length in clk cycles (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, max cycles waiting for lock per attempt (>=2).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, consecutive locked cycles required before release (>=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 4, failed lock attempts tolerated before fault (>=0).
REQ-005 clk  input  1  single clock; all logic in this domain.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pll_locked  input  1  PLL locked flag, asynchronous to clk.
REQ-008 restart  input  1  single-cycle request to restart the sequence.
REQ-009 pll_rst  output  1  active-high reset driven to the PLL rst pin.
REQ-010 sys_reset_n  output  1  active-low reset for PLL-clocked logic.
REQ-011 state_o  output  3  current state encoding.
REQ-012 fault  output  1  retries exhausted.
REQ-013 loss_cnt  output  8  lock-loss counter (present only with PLL_SEQ_LOSS_CNT_EN).

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; "locked" below means the synchronized value, 2-cycle latency.
REQ-015 States SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4; state_o reflects the registered state.
REQ-016 PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; locked -> STABLE; timer reaching LOCK_TIMEOUT without lock -> PLL_RST with retry_cnt+1, or -> FAULT if retry_cnt==MAX_RETRIES.
REQ-018 STABLE: count consecutive locked cycles; any unlocked cycle -> WAIT_LOCK with timer restarted, no retry increment; count reaching STABLE_CYCLES -> RUN.
REQ-019 RUN: sys_reset_n=1 and retry_cnt cleared on entry; unlocked -> PLL_RST, sys_reset_n=0 on the next clk edge.
REQ-020 sys_reset_n SHALL be 1 only in RUN; registered output, no glitches.
REQ-021 FAULT: fault=1, pll_rst=1, sys_reset_n=0; left only via restart.
REQ-022 restart in any state SHALL force PLL_RST next cycle, clear retry_cnt, timers and fault; restart beats any simultaneous transition.
REQ-023 All counters SHALL be sized with $clog2 of their limits and SHALL not wrap.

Reset
REQ-024 reset_n low SHALL asynchronously force state=PLL_RST, pll_rst=1, sys_reset_n=0, fault=0, loss_cnt=0, all counters 0, synchronizer flops 0.
REQ-025 Deassertion SHALL take effect on the next clk edge; PLL_RST then runs a full RST_CYCLES pulse.
REQ-026 reset_n low mid-sequence SHALL abandon the sequence with no residual counter state.

Configuration
REQ-027 With PLL_SEQ_LOSS_CNT_EN defined, loss_cnt SHALL increment on each RUN->PLL_RST caused by lock loss, saturate at 255 and clear only on reset_n; restart does not clear it.
REQ-028 Without PLL_SEQ_LOSS_CNT_EN, the loss_cnt port and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enum, its 3-bit width constant, and the loss-counter width (8).
REQ-030 Synchronizer SHALL be sub-module pll_seq_sync (2-flop, reset to 0), instantiated once.

Verification (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 Reset release, pll_locked raised 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles, sys_reset_n rises 2+8 cycles after lock, state_o=3.
REQ-032 pll_locked low 1 cycle during STABLE -> state_o returns to 1, stable count restarts, no retry consumed, release delayed by full 8 locked cycles.
REQ-033 pll_locked never asserted -> three 4-cycle pll_rst pulses each followed by 20 cycles in WAIT_LOCK, then fault=1, state_o=4, pll_rst=1.
REQ-034 In FAULT pulse restart, then lock -> fault=0, normal sequence to RUN; restart together with a WAIT_LOCK timeout -> PLL_RST, retry_cnt=0.
REQ-035 In RUN drop pll_locked -> sys_reset_n=0 within 3 cycles, pll_rst pulses; with PLL_SEQ_LOSS_CNT_EN, loss_cnt=1; 300 losses -> loss_cnt=255.
REQ-036 reset_n low mid-STABLE -> outputs take reset values immediately (asynchronously, before the next clk edge).

Source files
------------

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq_pkg
// Summary  : Shared state encoding and widths for the PLL lock sequencer.
// Revision : 1.0
// ============================================================================
package pll_seq_pkg;

    localparam int c_STATE_W    = 3;
    localparam int c_LOSS_CNT_W = 8;

    typedef enum logic [c_STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Width of a counter that holds 0 .. limit-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_seq_sync.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq_sync
// Summary  : Two-flop synchronizer for the asynchronous PLL locked flag.
// Revision : 1.0
// ============================================================================
module pll_seq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Summary  : PLL reset pulse, lock wait with retries, stability window, run
//            and fault handling. Define PLL_SEQ_LOSS_CNT_EN for loss_cnt.
// Revision : 1.0
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic                    restart,
    output logic                    pll_rst,
    output logic                    sys_reset_n,
    output logic [c_STATE_W-1:0]    state_o,
    output logic                    fault
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [c_LOSS_CNT_W-1:0] loss_cnt
`endif
);

    localparam int c_RST_W   = cnt_w(RST_CYCLES);
    localparam int c_TMR_W   = cnt_w(LOCK_TIMEOUT);
    localparam int c_STB_W   = cnt_w(STABLE_CYCLES);
    localparam int c_RETRY_W = cnt_w(MAX_RETRIES + 1);

    localparam logic [c_RST_W-1:0]   c_RST_LAST    = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_TMR_LAST    = c_TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_STB_W-1:0]   c_STB_LAST    = c_STB_W'(STABLE_CYCLES - 1);
    localparam logic [c_STB_W-1:0]   c_STB_ONE     = c_STB_W'(1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX   = c_RETRY_W'(MAX_RETRIES);
    localparam bit                   c_INSTANT_RUN = (STABLE_CYCLES == 1);

    pll_state_e             r_state;
    logic                   r_pll_rst;
    logic                   r_sys_reset_n;
    logic                   r_fault;
    logic [c_RST_W-1:0]     r_rst_cnt;
    logic [c_TMR_W-1:0]     r_timer;
    logic [c_STB_W-1:0]     r_stable_cnt;
    logic [c_RETRY_W-1:0]   r_retry_cnt;
    logic                   w_locked;

    pll_seq_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (pll_locked),
        .sync_out (w_locked)
    );

    // Outputs are registered alongside each transition so they track r_state exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= PLL_RST;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_fault       <= 1'b0;
            r_rst_cnt     <= '0;
            r_timer       <= '0;
            r_stable_cnt  <= '0;
            r_retry_cnt   <= '0;
        end else if (restart) begin
            r_state       <= PLL_RST;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_fault       <= 1'b0;
            r_rst_cnt     <= '0;
            r_timer       <= '0;
            r_stable_cnt  <= '0;
            r_retry_cnt   <= '0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_rst_cnt <= '0;
                        r_timer   <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // The locked cycle seen here is the first of the stability window.
                    if (w_locked) begin
                        r_timer <= '0;
                        if (c_INSTANT_RUN) begin
                            r_state       <= RUN;
                            r_sys_reset_n <= 1'b1;
                            r_retry_cnt   <= '0;
                        end else begin
                            r_state      <= STABLE;
                            r_stable_cnt <= c_STB_ONE;
                        end
                    end else if (r_timer == c_TMR_LAST) begin
                        r_timer   <= '0;
                        r_pll_rst <= 1'b1;
                        if (r_retry_cnt == c_RETRY_MAX) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state     <= PLL_RST;
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_rst_cnt   <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                STABLE: begin
                    if (!w_locked) begin
                        r_state      <= WAIT_LOCK;
                        r_timer      <= '0;
                        r_stable_cnt <= '0;
                    end else if (r_stable_cnt == c_STB_LAST) begin
                        r_state       <= RUN;
                        r_sys_reset_n <= 1'b1;
                        r_retry_cnt   <= '0;
                        r_stable_cnt  <= '0;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!w_locked) begin
                        r_state       <= PLL_RST;
                        r_pll_rst     <= 1'b1;
                        r_sys_reset_n <= 1'b0;
                        r_rst_cnt     <= '0;
                    end
                end
                FAULT: begin
                end
                default: begin
                    r_state       <= PLL_RST;
                    r_pll_rst     <= 1'b1;
                    r_sys_reset_n <= 1'b0;
                    r_fault       <= 1'b0;
                    r_rst_cnt     <= '0;
                end
            endcase
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_reset_n = r_sys_reset_n;
    assign fault       = r_fault;
    assign state_o     = r_state;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [c_LOSS_CNT_W-1:0] r_loss_cnt;
    logic                    w_loss_event;

    // A restart in the same cycle wins, so that exit is not a lock loss.
    assign w_loss_event = (r_state == RUN) && !w_locked && !restart;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_event && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    // Lock-loss counting is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Summary  : Randomized self-checking bench with an attempt-timing reference model.
// Revision : 1.0
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TMO   = 20;
    localparam int STB   = 8;
    localparam int MAXR  = 2;
    localparam int PER   = RST_C + TMO;
    localparam int NEVER = 1000000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_reset_n;
    logic [2:0] state_o;
    logic       fault;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
    int         exp_loss;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .state_o     (state_o),
        .fault       (fault)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt    (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Edge (relative to the origin edge) after which attempt a sits in WAIT_LOCK.
    function automatic int wait_start(input int a);
        return RST_C - 1 + a * PER;
    endfunction

    // Expected state after edge k, when the PLL flag rises after edge lock_at and
    // (optionally) drops for the single cycle after edge glitch_at.
    function automatic int exp_state(input int k, input int lock_at, input int glitch_at);
        int seen;
        int a_ok;
        int st;
        if (glitch_at >= 0 && k >= glitch_at + 3) begin
            if (k == glitch_at + 3) return 1;
            return (k < glitch_at + 3 + STB) ? 2 : 3;
        end
        seen = lock_at + 3;
        a_ok = -1;
        for (int a = 0; a <= MAXR; a++)
            if (a_ok < 0 && seen <= wait_start(a) + TMO) a_ok = a;
        if (a_ok >= 0) begin
            st = (seen > wait_start(a_ok)) ? seen : wait_start(a_ok) + 1;
            if (k >= st + STB - 1) return 3;
            if (k >= st) return 2;
        end else if (k >= wait_start(MAXR) + TMO) begin
            return 4;
        end
        for (int a = 0; a <= MAXR; a++) begin
            if (k < wait_start(a)) return 0;
            if (k < wait_start(a) + TMO) return 1;
        end
        return 4;
    endfunction

    task automatic check_outputs(input string tag, input int es);
        check_value({tag, " state"},       32'(state_o),     es);
        check_value({tag, " pll_rst"},     32'(pll_rst),     32'(es == 0 || es == 4));
        check_value({tag, " sys_reset_n"}, 32'(sys_reset_n), 32'(es == 3));
        check_value({tag, " fault"},       32'(fault),       32'(es == 4));
    endtask

    task automatic run_model(input string name, input int lock_at, input int glitch_at, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            pll_locked = (k >= lock_at) && (k != glitch_at);
            @(negedge clk);
            check_outputs($sformatf("%s k=%0d", name, k), exp_state(k, lock_at, glitch_at));
        end
    endtask

    task automatic start_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        @(negedge clk);
        check_outputs("reset", 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        exp_loss = 0;
        check_value("reset loss_cnt", 32'(loss_cnt), exp_loss);
`endif
        reset_n = 1'b1;
    endtask

    task automatic start_restart(input string name);
        restart    = 1'b1;
        pll_locked = 1'b0;
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);
        check_outputs({name, " restart"}, 0);
    endtask

    task automatic drop_lock_in_run(input string name);
        pll_locked = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("%s drop+%0d", name, i), (i < 3) ? 3 : 0);
        end
`ifdef PLL_SEQ_LOSS_CNT_EN
        if (exp_loss < 255) exp_loss++;
        check_value({name, " loss_cnt"}, 32'(loss_cnt), exp_loss);
`endif
    endtask

    task automatic wait_sys(input logic want, input int budget, input string tag);
        int n = 0;
        while (sys_reset_n !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, 32'(sys_reset_n), 32'(want));
    endtask

    initial begin
        int lk;
        int gl;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
        exp_loss   = 0;
`endif
        // Lock three cycles after the first pll_rst falling edge.
        start_reset();
        run_model("lock3", wait_start(0) + 3, -1, 30);

        for (int r = 0; r < 6; r++) begin
            lk = int'($urandom_range(0, 3 * PER + 4));
            if (r % 2 == 1) start_restart("rand");
            else            start_reset();
            run_model($sformatf("rand%0d L=%0d", r, lk), lk, -1, 100);
        end

        start_reset();
        lk = int'($urandom_range(1, 10));
        gl = lk + 1 + int'($urandom_range(0, 5));
        run_model($sformatf("glitch L=%0d G=%0d", lk, gl), lk, gl, 40);

        start_reset();
        run_model("nolock", NEVER, -1, 80);

        start_restart("fault");
        lk = int'($urandom_range(0, 12));
        run_model("fault_relock", lk, -1, 40);

        drop_lock_in_run("runloss");
        lk = int'($urandom_range(0, 12));
        run_model("relock", lk, -1, 40);

        // Restart lands on the same edge as the first lock timeout.
        start_reset();
        run_model("pre_tmo", NEVER, -1, wait_start(0) + TMO);
        start_restart("tmo");
        run_model("post_tmo", NEVER, -1, 80);

        start_reset();
        run_model("pre_async", 2, -1, 8);
        #2 reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        check_value("async_reset loss_cnt", 32'(loss_cnt), 0);
`endif
        start_reset();
        lk = int'($urandom_range(0, 12));
        run_model("post_async", lk, -1, 40);

`ifdef PLL_SEQ_LOSS_CNT_EN
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_sys(1'b0, 8, $sformatf("loss%0d drop", i));
            pll_locked = 1'b1;
            wait_sys(1'b1, 40, $sformatf("loss%0d relock", i));
            if (exp_loss < 255) exp_loss++;
        end
        check_value("loss_cnt saturated", 32'(loss_cnt), exp_loss);
        start_restart("loss_keep");
        check_value("loss_cnt after restart", 32'(loss_cnt), exp_loss);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, expected finish before 600000");
        $fatal(1);
    end

endmodule
`default_nettype wire
